// File: rtl/lcd_driver_n.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_driver_n
//  Description : Parametrised, registered LCD character driver for the alarm
//                clock. Selects one of three BCD sources (current time, alarm
//                time, keypad entry), converts each digit to ASCII, blinks the
//                keypad entry at 1 Hz and runs the alarm ringing / snooze FSM
//                that drives the buzzer enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_driver_n #(
    parameter int NUM_DIGITS    = 4,
    parameter int DIGIT_W       = 4,
    parameter int ALARM_TIMEOUT = 60,
    parameter int SNOOZE_SECS   = 300,
    parameter bit BLINK_EN      = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          one_second,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] alarm_time,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] current_time,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] key,
    input  logic                          show_a,
    input  logic                          show_current_time,
    input  logic                          alarm_on,
    input  logic                          alarm_button,
    input  logic                          snooze_button,
    output logic [NUM_DIGITS*8-1:0]       display,
    output logic                          sound_a
);

    localparam int c_CNT_MAX = (ALARM_TIMEOUT > SNOOZE_SECS) ? ALARM_TIMEOUT : SNOOZE_SECS;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_RING_LAST   = c_CNT_W'(ALARM_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_SNOOZE_LAST = c_CNT_W'(SNOOZE_SECS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_sound;
    logic                    r_blink_ph;
    logic                    r_match_q;
    logic                    r_run;
    logic [NUM_DIGITS*8-1:0] r_display;

    logic [NUM_DIGITS*DIGIT_W-1:0] w_sel;
    logic [NUM_DIGITS*8-1:0]       w_char;
    logic                          w_blank;
    logic                          w_match;
    logic                          w_match_rise;
    logic                          w_tick;

    // Source select: keypad entry outranks alarm view, which outranks the clock.
    assign w_sel = show_current_time ? key :
                   show_a            ? alarm_time : current_time;

    // Per-digit BCD to ASCII; anything above 9 shows as 'E'.
    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            logic [DIGIT_W-1:0] w_digit;
            assign w_digit = w_sel[g*DIGIT_W +: DIGIT_W];
            assign w_char[g*8 +: 8] = (32'(w_digit) < 32'd10) ?
                                      (8'h30 + 8'(w_digit)) : 8'h45;
        end
    endgenerate

    assign w_blank      = BLINK_EN && show_current_time && r_blink_ph;
    assign w_match      = (current_time == alarm_time);
    assign w_match_rise = w_match & ~r_match_q;
    // The first edge after reset release must not count a second.
    assign w_tick       = one_second & r_run;

    // Registered character output, blanked during the off phase of the blink.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_display <= {NUM_DIGITS{8'h30}};
        end else begin
            r_display <= w_blank ? {NUM_DIGITS{8'h20}} : w_char;
        end
    end

    // Blink phase, match edge history and post-reset run flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_ph <= 1'b0;
            r_match_q  <= 1'b0;
            r_run      <= 1'b0;
        end else begin
            if (one_second) begin
                r_blink_ph <= ~r_blink_ph;
            end
            r_match_q <= w_match;
            r_run     <= 1'b1;
        end
    end

    // Alarm FSM: ring on a match edge, stop, snooze, and timeouts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sound <= 1'b0;
        end else begin
            r_sound <= (r_state == ST_RINGING);
            if (!alarm_on) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_match_rise) begin
                            r_state <= ST_RINGING;
                            r_cnt   <= '0;
                        end
                    end
                    ST_RINGING: begin
                        if (alarm_button) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else if (snooze_button) begin
                            r_state <= ST_SNOOZE;
                            r_cnt   <= '0;
                        end else if (w_tick) begin
                            if (r_cnt == c_RING_LAST) begin
                                r_state <= ST_IDLE;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + c_CNT_ONE;
                            end
                        end
                    end
                    ST_SNOOZE: begin
                        if (alarm_button) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else if (w_tick) begin
                            if (r_cnt == c_SNOOZE_LAST) begin
                                r_state <= ST_RINGING;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + c_CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign display = r_display;
    assign sound_a = r_sound;

endmodule
`default_nettype wire

// File: tb/tb_lcd_driver_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_driver_n
//  Description : Scoreboard bench for lcd_driver_n. Drives a 4-digit default
//                instance and a 6-digit short-timeout steady instance from the
//                same stimulus; a reference model queues expected outputs and
//                a monitor compares them each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_driver_n;

    localparam int c_TO0 = 60;
    localparam int c_SN0 = 300;
    localparam int c_TO1 = 3;
    localparam int c_SN1 = 5;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        one_second;
    logic [23:0] alarm_time;
    logic [23:0] current_time;
    logic [23:0] key;
    logic        show_a;
    logic        show_current_time;
    logic        alarm_on;
    logic        alarm_button;
    logic        snooze_button;
    logic [31:0] display0;
    logic [47:0] display1;
    logic        sound0;
    logic        sound1;

    lcd_driver_n u_dut0 (
        .clock             (clk),
        .reset_n           (reset_n),
        .one_second        (one_second),
        .alarm_time        (alarm_time[15:0]),
        .current_time      (current_time[15:0]),
        .key               (key[15:0]),
        .show_a            (show_a),
        .show_current_time (show_current_time),
        .alarm_on          (alarm_on),
        .alarm_button      (alarm_button),
        .snooze_button     (snooze_button),
        .display           (display0),
        .sound_a           (sound0)
    );

    lcd_driver_n #(
        .NUM_DIGITS    (6),
        .DIGIT_W       (4),
        .ALARM_TIMEOUT (c_TO1),
        .SNOOZE_SECS   (c_SN1),
        .BLINK_EN      (1'b0)
    ) u_dut1 (
        .clock             (clk),
        .reset_n           (reset_n),
        .one_second        (one_second),
        .alarm_time        (alarm_time),
        .current_time      (current_time),
        .key               (key),
        .show_a            (show_a),
        .show_current_time (show_current_time),
        .alarm_on          (alarm_on),
        .alarm_button      (alarm_button),
        .snooze_button     (snooze_button),
        .display           (display1),
        .sound_a           (sound1)
    );

    typedef struct {
        logic [31:0] d0;
        logic        s0;
        logic [47:0] d1;
        logic        s1;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode 0 = quiet, 1 = ringing, 2 = snoozing; left = seconds remaining.
    int   mode[2];
    int   left[2];
    bit   mq[2];
    bit   blink[2];
    bit   first_run;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [47:0] render(input logic [23:0] v, input int n, input bit blank);
        logic [47:0] r;
        int d;
        r = '0;
        for (int i = 0; i < n; i++) begin
            d = int'(v[i*4 +: 4]);
            r[i*8 +: 8] = blank ? 8'h20 : ((d < 10) ? 8'(48 + d) : 8'h45);
        end
        return r;
    endfunction

    function automatic bit same(input logic [23:0] a, input logic [23:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            if (a[i*4 +: 4] != b[i*4 +: 4]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Predict outputs after the coming rising edge from the inputs now applied.
    task automatic commit();
        exp_t        e;
        logic [47:0] dsp[2];
        bit          snd[2];
        logic [23:0] sel;
        int          n, to, sn;
        bit          m, rise, tick, ben;
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                mode[i] = 0; left[i] = 0; mq[i] = 1'b0; blink[i] = 1'b0;
            end
            first_run = 1'b1;
            e.d0 = {4{8'h30}};
            e.d1 = {6{8'h30}};
            e.s0 = 1'b0;
            e.s1 = 1'b0;
        end else begin
            sel = show_current_time ? key : (show_a ? alarm_time : current_time);
            for (int i = 0; i < 2; i++) begin
                n    = (i == 0) ? 4 : 6;
                to   = (i == 0) ? c_TO0 : c_TO1;
                sn   = (i == 0) ? c_SN0 : c_SN1;
                ben  = (i == 0);
                m    = same(current_time, alarm_time, n);
                rise = m && !mq[i];
                tick = one_second && !first_run;
                snd[i] = (mode[i] == 1);
                dsp[i] = render(sel, n, ben && show_current_time && blink[i]);
                if (!alarm_on) begin
                    mode[i] = 0;
                end else if (mode[i] == 0) begin
                    if (rise) begin mode[i] = 1; left[i] = to; end
                end else if (mode[i] == 1) begin
                    if (alarm_button) mode[i] = 0;
                    else if (snooze_button) begin mode[i] = 2; left[i] = sn; end
                    else if (tick) begin
                        left[i]--;
                        if (left[i] == 0) mode[i] = 0;
                    end
                end else begin
                    if (alarm_button) mode[i] = 0;
                    else if (tick) begin
                        left[i]--;
                        if (left[i] == 0) begin mode[i] = 1; left[i] = to; end
                    end
                end
                mq[i] = m;
                if (one_second) blink[i] = !blink[i];
            end
            first_run = 1'b0;
            e.d0 = dsp[0][31:0];
            e.d1 = dsp[1];
            e.s0 = snd[0];
            e.s1 = snd[1];
        end
        q.push_back(e);
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            commit();
            @(negedge clk);
        end
    endtask

    task automatic pulse();
        one_second = 1'b1;
        cyc(1);
        one_second = 1'b0;
        cyc(1);
    endtask

    // Monitor: compare every registered output shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("display4", {16'h0, display0}, {16'h0, e.d0});
                chk("sound4",   {47'h0, sound0},   {47'h0, e.s0});
                chk("display6", display1,          e.d1);
                chk("sound6",   {47'h0, sound1},   {47'h0, e.s1});
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized soak.
    initial begin
        logic [15:0] lo_set[3];
        lo_set[0] = 16'h0700;
        lo_set[1] = 16'h0659;
        lo_set[2] = 16'h09A5;
        reset_n = 1'b0; one_second = 1'b0;
        alarm_time = '0; current_time = '0; key = '0;
        show_a = 1'b0; show_current_time = 1'b0; alarm_on = 1'b0;
        alarm_button = 1'b0; snooze_button = 1'b0;
        @(negedge clk);
        cyc(3);
        reset_n = 1'b1;
        cyc(2);

        // Source select and encoding.
        current_time = 24'h001234; alarm_time = 24'h000630; key = 24'h00095A;
        cyc(2);
        show_a = 1'b1;
        cyc(2);
        show_current_time = 1'b1;
        cyc(2);
        chk("mux_key_lit4", {16'h0, display0}, {16'h0, 32'h30393545});
        chk("mux_key_lit6", display1, 48'h303030393545);
        show_a = 1'b0;
        cyc(2);
        show_current_time = 1'b0;
        cyc(2);

        // Ring, then timeout with match still held.
        alarm_on = 1'b1; alarm_time = 24'h000700; current_time = 24'h000659;
        cyc(3);
        current_time = 24'h000700;
        cyc(3);
        chk("ring_on", {47'h0, sound0}, 48'h1);
        repeat (c_TO0) pulse();
        cyc(5);
        chk("timeout_no_rering", {47'h0, sound0}, 48'h0);

        // Snooze, re-ring, simultaneous stop and snooze.
        current_time = 24'h000659;
        cyc(2);
        current_time = 24'h000700;
        cyc(3);
        snooze_button = 1'b1;
        cyc(1);
        snooze_button = 1'b0;
        cyc(2);
        chk("snooze_quiet", {47'h0, sound0}, 48'h0);
        repeat (c_SN0) pulse();
        cyc(3);
        chk("snooze_rering", {47'h0, sound0}, 48'h1);
        alarm_button = 1'b1; snooze_button = 1'b1;
        cyc(1);
        alarm_button = 1'b0; snooze_button = 1'b0;
        cyc(2);
        chk("stop_wins", {47'h0, sound0}, 48'h0);

        // Disarm while ringing, then asynchronous reset while ringing.
        current_time = 24'h000659;
        cyc(2);
        current_time = 24'h000700;
        cyc(3);
        alarm_on = 1'b0;
        cyc(2);
        chk("disarm", {47'h0, sound0}, 48'h0);
        alarm_on = 1'b1; current_time = 24'h000659;
        cyc(2);
        current_time = 24'h000700;
        cyc(3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_disp4", {16'h0, display0}, {16'h0, 32'h30303030});
        chk("async_rst_disp6", display1, 48'h303030303030);
        chk("async_rst_sound", {47'h0, sound0}, 48'h0);
        commit();
        @(negedge clk);
        cyc(2);
        reset_n = 1'b1;
        cyc(4);
        alarm_button = 1'b1;
        cyc(1);
        alarm_button = 1'b0;

        // Blink of keypad entry.
        alarm_on = 1'b0; show_current_time = 1'b1; key = 24'h001200;
        cyc(2);
        repeat (6) begin
            one_second = 1'b1;
            cyc(1);
            one_second = 1'b0;
            cyc(3);
        end
        show_current_time = 1'b0;
        cyc(2);

        // Randomized soak.
        repeat (3000) begin
            one_second        = ($urandom_range(0, 3) == 0);
            show_a            = ($urandom_range(0, 7) == 0);
            show_current_time = ($urandom_range(0, 5) == 0);
            alarm_on          = ($urandom_range(0, 19) != 0);
            alarm_button      = ($urandom_range(0, 39) == 0);
            snooze_button     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) == 0)
                current_time = {($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00,
                                lo_set[$urandom_range(0, 2)]};
            if ($urandom_range(0, 49) == 0)
                alarm_time = {($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00,
                              lo_set[$urandom_range(0, 2)]};
            if ($urandom_range(0, 19) == 0)
                key = 24'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset_n = 1'b0;
                #1 chk("rand_async_rst", {47'h0, sound0}, 48'h0);
                commit();
                @(negedge clk);
                reset_n = 1'b1;
            end
            cyc(1);
        end
        one_second = 1'b0;
        cyc(2);

        @(posedge clk);
        #4;
        chk("queue_drained", 48'(q.size()), 48'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
